// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: shared state encoding, default word lengths and reference words for the serializer
// Ports: none (package). Optional feature macro used by the top: SHIFTREG_SERIALIZER_REPEAT_EN.
package shiftreg_pkg;
    typedef enum logic [1:0] {IDLE, DYN, STAT, GAP} state_t;
    localparam int DYN_LEN = 16;
    localparam int STAT_LEN = 88;
    localparam logic [DYN_LEN-1:0] DYN_DEFAULT = 16'hABCD;
    localparam logic [STAT_LEN-1:0] STAT_DEFAULT = 88'h123456789ABCDEF1234567;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        return m > c ? m : c;
    endfunction
endpackage

// File: rtl/shiftreg_piso.sv
// shiftreg_piso: parallel-load, left-shift register exposing its MSB
// Ports: clk, rst_n (async active low), load (capture d), shift (shift left, zero fill), d (parallel word), msb (current MSB)
module shiftreg_piso
    import shiftreg_pkg::*;
#(
    parameter int W = DYN_LEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);
    logic [W-1:0] q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (load) q <= d;
        else if (shift) q <= {q[W-2:0], 1'b0};
    assign msb = q[W-1];
endmodule

// File: rtl/shiftreg_serializer.sv
// shiftreg_serializer: serializes a dynamic then a static word MSB first with matching select strobes
// Ports: CLK, RST_N (async active low), load_valid/load_ready (accept handshake, ready = IDLE),
//        dyn_word, stat_word (parallel words), SELDYN, SELSTAT (select strobes), signal_out (serial data),
//        busy (frame in progress), frame_done (pulse in first gap cycle)
// Optional: define SHIFTREG_SERIALIZER_REPEAT_EN to resend the last accepted words whenever idle without load_valid.
module shiftreg_serializer
    import shiftreg_pkg::*;
#(
    parameter int SIZESRDYN  = DYN_LEN,
    parameter int SIZESRSTAT = STAT_LEN,
    parameter int SIZEGAP    = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [SIZESRDYN-1:0]  dyn_word,
    input  logic [SIZESRSTAT-1:0] stat_word,
    output logic                  SELDYN,
    output logic                  SELSTAT,
    output logic                  signal_out,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = $clog2(max3(SIZESRDYN, SIZESRSTAT, SIZEGAP) + 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic accept, start, last, dyn_msb, stat_msb;
    logic [SIZESRDYN-1:0] src_dyn;
    logic [SIZESRSTAT-1:0] src_stat;
    assign load_ready = state == IDLE;
    assign accept = load_valid && load_ready;
    assign last = cnt == CW'(1);
`ifdef SHIFTREG_SERIALIZER_REPEAT_EN
    logic sent;
    logic [SIZESRDYN-1:0] ret_dyn;
    logic [SIZESRSTAT-1:0] ret_stat;
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            sent <= 1'b0;
            ret_dyn <= '0;
            ret_stat <= '0;
        end else if (accept) begin
            sent <= 1'b1;
            ret_dyn <= dyn_word;
            ret_stat <= stat_word;
        end
    // A fresh load_valid in IDLE takes priority over the repeat.
    assign start = accept || (load_ready && sent);
    assign src_dyn = accept ? dyn_word : ret_dyn;
    assign src_stat = accept ? stat_word : ret_stat;
`else
    assign start = accept;
    assign src_dyn = dyn_word;
    assign src_stat = stat_word;
`endif
    // The dynamic MSB goes straight to signal_out on the start edge, so its shadow is
    // loaded pre-shifted; the static shadow shifts from the DYN->STAT edge onward.
    shiftreg_piso #(.W(SIZESRDYN)) u_dyn (
        .clk(CLK), .rst_n(RST_N), .load(start), .shift(state == DYN),
        .d({src_dyn[SIZESRDYN-2:0], 1'b0}), .msb(dyn_msb)
    );
    shiftreg_piso #(.W(SIZESRSTAT)) u_stat (
        .clk(CLK), .rst_n(RST_N), .load(start), .shift((state == DYN && last) || state == STAT),
        .d(src_stat), .msb(stat_msb)
    );
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state <= IDLE;
            cnt <= '0;
            SELDYN <= 1'b0;
            SELSTAT <= 1'b0;
            signal_out <= 1'b0;
            busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= DYN;
                    cnt <= CW'(SIZESRDYN);
                    SELDYN <= 1'b1;
                    signal_out <= src_dyn[SIZESRDYN-1];
                    busy <= 1'b1;
                end
                DYN: if (last) begin
                    state <= STAT;
                    cnt <= CW'(SIZESRSTAT);
                    SELDYN <= 1'b0;
                    SELSTAT <= 1'b1;
                    signal_out <= stat_msb;
                end else begin
                    cnt <= cnt - CW'(1);
                    signal_out <= dyn_msb;
                end
                STAT: if (last) begin
                    state <= GAP;
                    cnt <= CW'(SIZEGAP);
                    SELSTAT <= 1'b0;
                    signal_out <= 1'b0;
                    frame_done <= 1'b1;
                end else begin
                    cnt <= cnt - CW'(1);
                    signal_out <= stat_msb;
                end
                GAP: if (last) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else cnt <= cnt - CW'(1);
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_shiftreg_serializer.sv
// tb_shiftreg_serializer: scoreboard bench for the serializer (default build and a short-frame instance)
module tb_shiftreg_serializer;
    import shiftreg_pkg::*;
    typedef struct packed {logic sd; logic b;} exp_t;
    logic CLK = 1'b0;
    logic RST_N;
    logic load_valid, load_ready, SELDYN, SELSTAT, signal_out, busy, frame_done;
    logic [15:0] dyn_word;
    logic [87:0] stat_word;
    logic s_valid, s_ready, s_seldyn, s_selstat, s_out, s_busy, s_done;
    logic [3:0] s_dyn;
    logic [7:0] s_stat;
    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    shiftreg_serializer dut (
        .CLK(CLK), .RST_N(RST_N), .load_valid(load_valid), .load_ready(load_ready),
        .dyn_word(dyn_word), .stat_word(stat_word), .SELDYN(SELDYN), .SELSTAT(SELSTAT),
        .signal_out(signal_out), .busy(busy), .frame_done(frame_done)
    );

    shiftreg_serializer #(.SIZESRDYN(4), .SIZESRSTAT(8), .SIZEGAP(1)) dut_small (
        .CLK(CLK), .RST_N(RST_N), .load_valid(s_valid), .load_ready(s_ready),
        .dyn_word(s_dyn), .stat_word(s_stat), .SELDYN(s_seldyn), .SELSTAT(s_selstat),
        .signal_out(s_out), .busy(s_busy), .frame_done(s_done)
    );

    // Scoreboard comparator: every cycle with a select high consumes one expected bit.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (RST_N === 1'b1) begin
            checks++;
            if (SELDYN && SELSTAT) begin
                errors++;
                $display("FAIL sel_overlap: SELDYN=%b SELSTAT=%b, required not both 1", SELDYN, SELSTAT);
            end else if (!SELDYN && !SELSTAT) begin
                if (signal_out !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_out: signal_out=%b with no select, required 0", signal_out);
                end
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bit: SELDYN=%b SELSTAT=%b with empty scoreboard", SELDYN, SELSTAT);
            end else begin
                e = exp_q.pop_front();
                if ({SELDYN, signal_out} !== {e.sd, e.b}) begin
                    errors++;
                    $display("FAIL serial_bit: SELDYN,out=%b%b required %b%b", SELDYN, signal_out, e.sd, e.b);
                end
            end
        end
    end

    function automatic logic [87:0] rand88();
        return {24'($urandom), $urandom, $urandom};
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [87:0] s);
        for (int i = 15; i >= 0; i--) exp_q.push_back({1'b1, d[i]});
        for (int i = 87; i >= 0; i--) exp_q.push_back({1'b0, s[i]});
    endtask

    task automatic do_reset();
        #2 RST_N = 1'b0;
        load_valid = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic accept(input logic [15:0] d, input logic [87:0] s);
        @(negedge CLK);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_accept: load_ready=%b required 1", load_ready);
        end
        load_valid = 1'b1;
        dyn_word = d;
        stat_word = s;
        push_frame(d, s);
        @(posedge CLK);
        #1 load_valid = 1'b0;
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d bits left unsent, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        #1 RST_N = 1'b0;
        #1;
        checks++;
        if ({SELDYN, SELSTAT, signal_out, busy, frame_done, load_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_initial: outs=%b required 000001",
                     {SELDYN, SELSTAT, signal_out, busy, frame_done, load_ready});
        end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        accept(DYN_DEFAULT, STAT_DEFAULT);
        for (int k = 1; k <= 57; k++) @(negedge CLK);
        checks++;
        if (SELSTAT !== 1'b1) begin
            errors++;
            $display("FAIL reset_prestate: SELSTAT=%b at cycle 57, required 1", SELSTAT);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({SELDYN, SELSTAT, signal_out, busy, frame_done, load_ready} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_midframe: outs=%b required 000001",
                     {SELDYN, SELSTAT, signal_out, busy, frame_done, load_ready});
        end
        exp_q.delete();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            checks++;
            if (SELDYN || SELSTAT || busy || !load_ready) begin
                errors++;
                $display("FAIL reset_no_resume: sel=%b%b busy=%b ready=%b required 0 0 0 1",
                         SELDYN, SELSTAT, busy, load_ready);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [4:0] want;
        do_reset();
        accept(DYN_DEFAULT, STAT_DEFAULT);
        for (int k = 1; k <= 107; k++) begin
            @(negedge CLK);
            want = {k <= 16, k >= 17 && k <= 104, k <= 106, k == 105, k >= 107};
            checks++;
            if ({SELDYN, SELSTAT, busy, frame_done, load_ready} !== want) begin
                errors++;
                $display("FAIL single_frame_timing: cycle %0d sd,ss,busy,done,ready=%b required %b",
                         k, {SELDYN, SELSTAT, busy, frame_done, load_ready}, want);
            end
        end
        check_empty("single_frame_drain");
    endtask

    task automatic test_back_to_back();
        logic [87:0] s0, s1;
        logic prev;
        int rises;
        s0 = rand88();
        s1 = rand88();
        do_reset();
        @(negedge CLK);
        load_valid = 1'b1;
        dyn_word = 16'h0000;
        stat_word = s0;
        push_frame(16'h0000, s0);
        push_frame(16'hFFFF, s1);
        @(posedge CLK);
        #1 dyn_word = 16'hFFFF;
        stat_word = s1;
        prev = 1'b0;
        rises = 0;
        for (int k = 1; k <= 214; k++) begin
            @(negedge CLK);
            if (SELDYN && !prev) begin
                checks++;
                if (k != (rises == 0 ? 1 : 108)) begin
                    errors++;
                    $display("FAIL b2b_rise: SELDYN rise %0d at cycle %0d, required %0d",
                             rises, k, rises == 0 ? 1 : 108);
                end
                rises++;
            end
            prev = SELDYN;
            if (k == 108) load_valid = 1'b0;
        end
        checks++;
        if (rises != 2) begin
            errors++;
            $display("FAIL b2b_count: %0d frames started, required 2", rises);
        end
        check_empty("b2b_drain");
    endtask

    task automatic test_isolation();
        do_reset();
        accept(16'($urandom), rand88());
        for (int k = 1; k <= 107; k++) begin
            @(negedge CLK);
            dyn_word = 16'($urandom);
            stat_word = rand88();
        end
        check_empty("isolation_drain");
    endtask

    task automatic test_min_gap();
        logic [3:0] d;
        logic [7:0] s;
        logic sd, ss, b;
        logic [4:0] want;
        d = 4'b1011;
        s = 8'hC5;
        do_reset();
        @(negedge CLK);
        s_valid = 1'b1;
        s_dyn = d;
        s_stat = s;
        @(posedge CLK);
        #1 s_valid = 1'b0;
        s_dyn = ~d;
        s_stat = ~s;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            sd = k <= 4;
            ss = k >= 5 && k <= 12;
            b = sd ? d[4-k] : ss ? s[12-k] : 1'b0;
            want = {sd, ss, b, k == 13, k >= 14};
            checks++;
            if ({s_seldyn, s_selstat, s_out, s_done, s_ready} !== want) begin
                errors++;
                $display("FAIL min_gap: cycle %0d sd,ss,out,done,ready=%b required %b",
                         k, {s_seldyn, s_selstat, s_out, s_done, s_ready}, want);
            end
        end
    endtask

    task automatic test_repeat();
`ifdef SHIFTREG_SERIALIZER_REPEAT_EN
        logic [15:0] da, db;
        logic [87:0] sa, sb;
        logic prev;
        int rises;
        da = 16'($urandom);
        db = ~da;
        sa = rand88();
        sb = rand88();
        do_reset();
        @(negedge CLK);
        load_valid = 1'b1;
        dyn_word = da;
        stat_word = sa;
        push_frame(da, sa);
        push_frame(da, sa);
        @(posedge CLK);
        #1 load_valid = 1'b0;
        prev = 1'b0;
        rises = 0;
        for (int k = 1; k <= 428; k++) begin
            @(negedge CLK);
            if (SELDYN && !prev) begin
                checks++;
                if (k != 1 + 107 * rises) begin
                    errors++;
                    $display("FAIL repeat_rise: frame %0d at cycle %0d, required %0d", rises, k, 1 + 107 * rises);
                end
                rises++;
            end
            prev = SELDYN;
            if (k == 214) begin
                load_valid = 1'b1;
                dyn_word = db;
                stat_word = sb;
                push_frame(db, sb);
                push_frame(db, sb);
            end
            if (k == 215) load_valid = 1'b0;
        end
        checks++;
        if (rises != 4) begin
            errors++;
            $display("FAIL repeat_count: %0d frames started, required 4", rises);
        end
        check_empty("repeat_drain");
`endif
    endtask

    initial begin
        RST_N = 1'b1;
        load_valid = 1'b0;
        dyn_word = '0;
        stat_word = '0;
        s_valid = 1'b0;
        s_dyn = '0;
        s_stat = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_isolation();
        test_min_gap();
        test_repeat();
        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
